// File: rtl/alu_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// the default datapath width. The ALU control decoder imports the same codes.
package alu_multiciclo_pkg;

    localparam int LARGURA_PADRAO = 32;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_AND  = 6'b000001;
    localparam logic [5:0] OP_DIV  = 6'b000010;
    localparam logic [5:0] OP_MULT = 6'b000011;
    localparam logic [5:0] OP_SUB  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b000101;
    localparam logic [5:0] OP_NOR  = 6'b000110;
    localparam logic [5:0] OP_XOR  = 6'b000111;
    localparam logic [5:0] OP_SLT  = 6'b001000;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EXEC   = 2'd1,
        ITERA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    // mult and div run through the iterative datapath; everything else is one cycle
    function automatic logic eh_iterativa(input logic [5:0] codigo);
        return (codigo == OP_MULT) || (codigo == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_multiciclo_if.sv
// Handshake and data bus of the multi-cycle ALU. The master side issues
// operations, the slave side (the ALU) returns results and status.
interface alu_multiciclo_if #(
    parameter int LARGURA = 32
);
    logic               Inicio;
    logic [5:0]         Controle;
    logic [LARGURA-1:0] A;
    logic [LARGURA-1:0] B;
    logic [LARGURA-1:0] Resultado;
    logic [LARGURA-1:0] Hi;
    logic [LARGURA-1:0] Lo;
    logic               Zero;
    logic               Overflow;
    logic               Ocupado;
    logic               Pronto;

    modport master (
        output Inicio, Controle, A, B,
        input  Resultado, Hi, Lo, Zero, Overflow, Ocupado, Pronto
    );

    modport slave (
        input  Inicio, Controle, A, B,
        output Resultado, Hi, Lo, Zero, Overflow, Ocupado, Pronto
    );

endinterface

// File: rtl/alu_multiciclo_mult_div_iterativo.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle over 32 iterations. The hi/lo register pair is shared by both:
// mult keeps {partial product, remaining multiplier}, div keeps
// {partial remainder, dividend shifting into quotient}.
module mult_div_iterativo #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic               divisao,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo,
    output logic               pronto
);

    logic [LARGURA-1:0] hi_q;
    logic [LARGURA-1:0] lo_q;
    logic [LARGURA-1:0] m_q;
    logic               divisao_q;
    logic               ativo;
    logic [5:0]         contador;

    logic [LARGURA:0]   soma_mult;
    logic [LARGURA-1:0] mult_hi_prox;
    logic [LARGURA-1:0] mult_lo_prox;
    logic [LARGURA:0]   desloc;
    logic               cabe;
    logic [LARGURA-1:0] resto_sub;
    logic [LARGURA-1:0] div_resto_prox;
    logic [LARGURA-1:0] div_quoc_prox;

    // next value of one shift-add step and of one restoring-division step
    always_comb begin
        soma_mult      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        mult_hi_prox   = soma_mult[LARGURA:1];
        mult_lo_prox   = {soma_mult[0], lo_q[LARGURA-1:1]};
        desloc         = {hi_q, lo_q[LARGURA-1]};
        cabe           = desloc >= {1'b0, m_q};
        resto_sub      = desloc[LARGURA-1:0] - m_q;
        div_resto_prox = cabe ? resto_sub : desloc[LARGURA-1:0];
        div_quoc_prox  = {lo_q[LARGURA-2:0], cabe};
    end

    // load operands on start, then iterate with a 0..31 counter and pulse pronto
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            divisao_q <= 1'b0;
            ativo     <= 1'b0;
            contador  <= '0;
            pronto    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (inicio) begin
                hi_q      <= '0;
                lo_q      <= divisao ? a : b;
                m_q       <= divisao ? b : a;
                divisao_q <= divisao;
                ativo     <= 1'b1;
                contador  <= '0;
            end else if (ativo) begin
                if (divisao_q) begin
                    hi_q <= div_resto_prox;
                    lo_q <= div_quoc_prox;
                end else begin
                    hi_q <= mult_hi_prox;
                    lo_q <= mult_lo_prox;
                end
                if (contador == 6'd31) begin
                    ativo  <= 1'b0;
                    pronto <= 1'b1;
                end else begin
                    contador <= contador + 6'd1;
                end
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative mult/div,
// sequenced by an OCIOSO/EXEC/ITERA/FIM state machine with registered outputs.
module alu_multiciclo
    import alu_multiciclo_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    alu_multiciclo_if.slave   bus
);

    estado_t            estado;
    logic [5:0]         op_q;
    logic [LARGURA-1:0] a_q;
    logic [LARGURA-1:0] b_q;
    logic [LARGURA-1:0] resultado_q;
    logic [LARGURA-1:0] hi_q;
    logic [LARGURA-1:0] lo_q;
    logic               zero_q;
    logic               overflow_q;
    logic               ocupado_q;
    logic               pronto_q;

    logic               aceita;
    logic               md_inicio;
    logic [LARGURA-1:0] md_hi;
    logic [LARGURA-1:0] md_lo;
    logic               md_pronto;

    logic               eh_sub;
    logic [LARGURA-1:0] b_efetivo;
    logic [LARGURA-1:0] soma;
    logic [LARGURA-1:0] res_comb;
    logic               ovf_comb;

    // a new operation is taken in OCIOSO, or in FIM for back-to-back issue
    assign aceita    = ((estado == OCIOSO) || (estado == FIM)) && bus.Inicio;
    assign md_inicio = aceita && eh_iterativa(bus.Controle);

    mult_div_iterativo #(
        .LARGURA (LARGURA)
    ) u_mult_div (
        .clock   (clock),
        .reset   (reset),
        .inicio  (md_inicio),
        .divisao (bus.Controle == OP_DIV),
        .a       (bus.A),
        .b       (bus.B),
        .hi      (md_hi),
        .lo      (md_lo),
        .pronto  (md_pronto)
    );

    // single-cycle result from the captured operands; sub reuses the adder with ~B + 1
    always_comb begin
        eh_sub    = (op_q == OP_SUB);
        b_efetivo = eh_sub ? ~b_q : b_q;
        soma      = a_q + b_efetivo + {{(LARGURA-1){1'b0}}, eh_sub};
        res_comb  = '0;
        ovf_comb  = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_comb = soma;
                ovf_comb = (a_q[LARGURA-1] == b_efetivo[LARGURA-1]) &&
                           (soma[LARGURA-1] != a_q[LARGURA-1]);
            end
            OP_AND:  res_comb = a_q & b_q;
            OP_OR:   res_comb = a_q | b_q;
            OP_NOR:  res_comb = ~(a_q | b_q);
            OP_XOR:  res_comb = a_q ^ b_q;
            OP_SLT:  res_comb = {{(LARGURA-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: res_comb = '0;
        endcase
    end

    // operation sequencing; outputs only change when an operation completes
    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resultado_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            case (estado)
                OCIOSO, FIM: begin
                    pronto_q <= 1'b0;
                    if (aceita) begin
                        a_q       <= bus.A;
                        b_q       <= bus.B;
                        op_q      <= bus.Controle;
                        ocupado_q <= 1'b1;
                        estado    <= eh_iterativa(bus.Controle) ? ITERA : EXEC;
                    end else begin
                        ocupado_q <= 1'b0;
                        estado    <= OCIOSO;
                    end
                end
                EXEC: begin
                    resultado_q <= res_comb;
                    zero_q      <= (res_comb == '0);
                    overflow_q  <= ovf_comb;
                    pronto_q    <= 1'b1;
                    ocupado_q   <= 1'b0;
                    estado      <= FIM;
                end
                ITERA: begin
                    if (md_pronto) begin
                        hi_q        <= md_hi;
                        lo_q        <= md_lo;
                        resultado_q <= md_lo;
                        zero_q      <= (md_lo == '0);
                        overflow_q  <= 1'b0;
                        pronto_q    <= 1'b1;
                        ocupado_q   <= 1'b0;
                        estado      <= FIM;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.Resultado = resultado_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = overflow_q;
    assign bus.Ocupado   = ocupado_q;
    assign bus.Pronto    = pronto_q;

endmodule
